// File: rtl/bcd_updown_counter_if.sv
// ---------------------------------------------------------------------------
// bcd_updown_counter_if
// Bundles the control inputs and the registered count outputs of the BCD
// up/down counter. The master side (stimulus or an upstream block) drives the
// controls. The slave side (the counter itself) drives the count, carry and
// zero flag.
// ---------------------------------------------------------------------------
interface bcd_updown_counter_if #(
  parameter int DIGITS = 4
);

  logic                  en;
  logic                  d;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   q;
  logic                  c;
  logic                  zero;

  modport master (
    output en,
    output d,
    output load,
    output load_val,
    input  q,
    input  c,
    input  zero
  );

  modport slave (
    input  en,
    input  d,
    input  load,
    input  load_val,
    output q,
    output c,
    output zero
  );

endinterface

// File: rtl/bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// bcd_updown_counter
// Multi-decade BCD up/down counter with the following features:
//   - count enable
//   - synchronous parallel load, which has priority over counting
//   - registered zero flag
//   - registered one-cycle carry/borrow pulse on wrap, for cascading
//
// Cascading: connect c of the lower stage to en of the upper stage, and share
// d between them. The upper stage then steps one cycle after the lower stage
// wraps.
//
// Optional feature macro: BCD_COUNTER_SATURATE_EN
//   - Defined: the count pins at all-9s (counting up) or at 0 (counting down).
//     c pulses on every enabled step that tries to pass the limit.
//   - Undefined: the count wraps around.
// ---------------------------------------------------------------------------
module bcd_updown_counter #(
  parameter int DIGITS     = 4,
  parameter bit LOAD_CLAMP = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  bcd_updown_counter_if.slave  bus
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]    q_r;
  logic [W-1:0]    q_next;
  logic [W-1:0]    load_clean;
  logic [W-1:0]    count_val;
  logic            c_r;
  logic            c_next;
  logic            zero_r;
  logic            zero_next;
  logic [DIGITS-1:0] up_step;
  logic [DIGITS-1:0] dn_step;
  logic            run_up;
  logic            run_dn;
  logic            all_nines;
  logic            all_zeros;
  logic            at_limit;

  // Sanitise the load value per decade, so that no invalid BCD digit can ever
  // enter the count register.
  always_comb begin
    load_clean = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.load_val[4*i +: 4] > 4'd9) begin
        load_clean[4*i +: 4] = LOAD_CLAMP ? 4'd9 : 4'd0;
      end else begin
        load_clean[4*i +: 4] = bus.load_val[4*i +: 4];
      end
    end
  end

  // Ripple enables: a decade steps only when every lower decade sits at its
  // rollover digit (9 when counting up, 0 when counting down).
  always_comb begin
    up_step = '0;
    dn_step = '0;
    run_up  = 1'b1;
    run_dn  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      up_step[i] = run_up;
      dn_step[i] = run_dn;
      run_up     = run_up & (q_r[4*i +: 4] == 4'd9);
      run_dn     = run_dn & (q_r[4*i +: 4] == 4'd0);
    end
    all_nines = run_up;
    all_zeros = run_dn;
  end

  // Compute the stepped count, and the limit condition that produces c.
  always_comb begin
    count_val = q_r;
    at_limit  = bus.d ? all_zeros : all_nines;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bus.d) begin
        if (up_step[i]) begin
          count_val[4*i +: 4] = (q_r[4*i +: 4] == 4'd9) ? 4'd0
                                                        : q_r[4*i +: 4] + 4'd1;
        end
      end else begin
        if (dn_step[i]) begin
          count_val[4*i +: 4] = (q_r[4*i +: 4] == 4'd0) ? 4'd9
                                                        : q_r[4*i +: 4] - 4'd1;
        end
      end
    end
`ifdef BCD_COUNTER_SATURATE_EN
    if (at_limit) begin
      count_val = q_r;
    end
`endif
  end

  // Next-state selection: load wins over count, and count wins over hold.
  always_comb begin
    q_next    = q_r;
    c_next    = 1'b0;
    zero_next = zero_r;
    if (bus.load) begin
      q_next    = load_clean;
      zero_next = (load_clean == '0);
    end else if (bus.en) begin
      q_next    = count_val;
      c_next    = at_limit;
      zero_next = (count_val == '0);
    end
  end

  // State register. Asynchronous reset clears the count and drops any pending
  // carry pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_r    <= '0;
      c_r    <= 1'b0;
      zero_r <= 1'b1;
    end else begin
      q_r    <= q_next;
      c_r    <= c_next;
      zero_r <= zero_next;
    end
  end

  assign bus.q    = q_r;
  assign bus.c    = c_r;
  assign bus.zero = zero_r;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_updown_counter
// Two-digit counters, one with clamping load and one with zeroing load, driven
// by the same stimulus. Each is compared against an integer model of the count.
// ---------------------------------------------------------------------------
module tb_bcd_updown_counter;

  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;
  localparam int MAXV   = 10 ** DIGITS - 1;

  logic         clk;
  logic         reset_n;
  logic         en;
  logic         d;
  logic         load;
  logic [W-1:0] load_val;

  int checks;
  int errors;
  int mv [2];
  bit mc [2];
  bit mz [2];

  bcd_updown_counter_if #(.DIGITS(DIGITS)) bus1 ();
  bcd_updown_counter_if #(.DIGITS(DIGITS)) bus0 ();

  assign bus1.en       = en;
  assign bus1.d        = d;
  assign bus1.load     = load;
  assign bus1.load_val = load_val;
  assign bus0.en       = en;
  assign bus0.d        = d;
  assign bus0.load     = load;
  assign bus0.load_val = load_val;

  bcd_updown_counter #(.DIGITS(DIGITS), .LOAD_CLAMP(1'b1)) dut_clamp (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  bcd_updown_counter #(.DIGITS(DIGITS), .LOAD_CLAMP(1'b0)) dut_zero (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] int_to_bcd(input int n);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((n / (10 ** i)) % 10);
    end
    return r;
  endfunction

  function automatic int load_value(input logic [W-1:0] lv, input bit clamp);
    int r;
    int nib;
    r = 0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = int'(lv[4*i +: 4]);
      if (nib > 9) nib = clamp ? 9 : 0;
      r += nib * (10 ** i);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mv[k] = 0;
      mc[k] = 1'b0;
      mz[k] = 1'b1;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      mc[k] = 1'b0;
      if (load) begin
        mv[k] = load_value(load_val, k == 1);
      end else if (en) begin
        if (!d) begin
          if (mv[k] == MAXV) begin
            mc[k] = 1'b1;
`ifndef BCD_COUNTER_SATURATE_EN
            mv[k] = 0;
`endif
          end else begin
            mv[k] = mv[k] + 1;
          end
        end else begin
          if (mv[k] == 0) begin
            mc[k] = 1'b1;
`ifndef BCD_COUNTER_SATURATE_EN
            mv[k] = MAXV;
`endif
          end else begin
            mv[k] = mv[k] - 1;
          end
        end
      end
      if (load || en) mz[k] = (mv[k] == 0);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [W-1:0] e1;
    logic [W-1:0] e0;
    e1 = int_to_bcd(mv[1]);
    e0 = int_to_bcd(mv[0]);
    checks++;
    assert (bus1.q === e1) else begin
      errors++;
      $error("[TB] FAIL %s q(clamp): got %h expected %h", tag, bus1.q, e1);
    end
    checks++;
    assert (bus1.c === mc[1]) else begin
      errors++;
      $error("[TB] FAIL %s c(clamp): got %b expected %b", tag, bus1.c, mc[1]);
    end
    checks++;
    assert (bus1.zero === mz[1]) else begin
      errors++;
      $error("[TB] FAIL %s zero(clamp): got %b expected %b", tag, bus1.zero, mz[1]);
    end
    checks++;
    assert (bus0.q === e0) else begin
      errors++;
      $error("[TB] FAIL %s q(zeroing): got %h expected %h", tag, bus0.q, e0);
    end
    checks++;
    assert (bus0.c === mc[0]) else begin
      errors++;
      $error("[TB] FAIL %s c(zeroing): got %b expected %b", tag, bus0.c, mc[0]);
    end
    checks++;
    assert (bus0.zero === mz[0]) else begin
      errors++;
      $error("[TB] FAIL %s zero(zeroing): got %b expected %b", tag, bus0.zero, mz[0]);
    end
  endtask

  task automatic applyStimulus(input bit ld, input bit e, input bit dir,
                               input logic [W-1:0] lv, input string tag);
    load     = ld;
    en       = e;
    d        = dir;
    load_val = lv;
    @(posedge clk);
    model_step();
    #1;
    checkOutput(tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checkOutput(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset_n  = 1'b0;
    en       = 1'b0;
    d        = 1'b0;
    load     = 1'b0;
    load_val = '0;
    model_reset();
    #12;
    checkOutput("reset");
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] first count after reset release");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, "first_up");

    $display("[TB] mid-count asynchronous reset");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h37, "load37");
    async_reset("reset_mid");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, "after_reset");

    $display("[TB] up wrap");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h98, "load98");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, "up_99");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, "up_wrap");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, "up_01");

    $display("[TB] down borrow");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h10, "load10");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h00, "down_09");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h00, "down_08");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, "load00");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h00, "down_wrap");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h00, "down_after");

    $display("[TB] load priority and sanitising");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hA3, "load_A3");
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h5F, "load_5F");

    $display("[TB] hold and direction flip");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h42, "load42");
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'(i), 8'h00, "hold");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, "flip_up");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h00, "flip_down");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, "flip_up2");

    $display("[TB] limits");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h99, "load99");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, "limit_up1");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, "limit_up2");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, "load0");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h00, "limit_dn1");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h00, "limit_dn2");

    $display("[TB] randomized stimulus");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        async_reset("rand_reset");
      end
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                    1'($urandom_range(0, 1)), W'($urandom), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
